arithcrypt_seq_core: RTL and testbench

ARITHCRYPT_SEQ_CORE -- requirements
Module: arithcrypt_seq_core

---
 rtl/arithcrypt_seq_core.sv | 159 +++++++++++++++
 tb/tb_arithcrypt_seq_core.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/arithcrypt_seq_core.sv
// Sequential arithmetic / toy-cipher core: single-cycle ADD/SUB/XOR/ROTL,
// iterative shift-add MUL and a rotate-add-xor round cipher (ENC/DEC).
module arithcrypt_seq_core #(
    parameter int WIDTH  = 8,
    parameter int ROUNDS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy,
    output logic             err,
    output logic [1:0]       o_dbg_state
);

    localparam int SW     = $clog2(WIDTH);
    localparam int CW     = 6;
    localparam int DEC_SH = (ROUNDS - 1) % WIDTH;
    localparam logic [CW-1:0] MUL_CNT = CW'(WIDTH);
    localparam logic [CW-1:0] RND_CNT = CW'(ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [3:0]       r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_mb;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] w_quick_res;
    logic             w_quick_err;
    logic             w_is_iter;
    logic [WIDTH-1:0] w_x_next;
    logic [WIDTH-1:0] w_k_next;
    logic [WIDTH-1:0] w_mb_next;
    logic             w_last;

    function automatic logic [WIDTH-1:0] rotl1(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotr1(input logic [WIDTH-1:0] x);
        return {x[0], x[WIDTH-1:1]};
    endfunction

    function automatic logic [WIDTH-1:0] rotl_n(input logic [WIDTH-1:0] x, input logic [SW-1:0] sh);
        logic [2*WIDTH-1:0] t;
        t = {x, x} << sh;
        return t[2*WIDTH-1:WIDTH];
    endfunction

    assign w_is_iter   = (op == 4'd4) || (op == 4'd5) || (op == 4'd6);
    assign w_last      = (r_cnt == CW'(1));
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign o_dbg_state = r_state;

    // Single-cycle results are computed straight from the live inputs on the sampling edge.
    always_comb begin
        w_quick_res = '0;
        w_quick_err = 1'b0;
        case (op)
            4'd0:    w_quick_res = a + b;
            4'd1:    w_quick_res = a - b;
            4'd2:    w_quick_res = a ^ b;
            4'd3:    w_quick_res = rotl_n(a, b[SW-1:0]);
            default: w_quick_err = 1'b1;
        endcase
    end

    always_comb begin
        w_x_next  = r_x;
        w_k_next  = r_k;
        w_mb_next = r_mb;
        case (r_op)
            4'd4: begin
                w_x_next  = r_x + (r_mb[0] ? r_k : '0);
                w_k_next  = r_k << 1;
                w_mb_next = r_mb >> 1;
            end
            4'd5: begin
                w_x_next = rotl1(r_x + r_k) ^ r_k;
                w_k_next = rotl1(r_k);
            end
            4'd6: begin
                w_x_next = rotr1(r_x ^ r_k) - r_k;
                w_k_next = rotr1(r_k);
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_next = w_is_iter ? S_RUN : S_DONE;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_x     <= '0;
            r_k     <= '0;
            r_mb    <= '0;
            r_cnt   <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_op  <= op;
                    r_cnt <= (op == 4'd4) ? MUL_CNT : RND_CNT;
                    r_mb  <= '0;
                    r_x   <= a;
                    r_k   <= b;
                    if (op == 4'd4) begin
                        r_x  <= '0;
                        r_k  <= a;
                        r_mb <= b;
                    end else if (op == 4'd6) begin
                        // Decryption walks the key schedule backwards from the last round key.
                        r_k <= rotl_n(b, SW'(DEC_SH));
                    end
                    if (!w_is_iter) begin
                        result <= w_quick_res;
                        err    <= w_quick_err;
                    end
                end
                S_RUN: begin
                    r_x   <= w_x_next;
                    r_k   <= w_k_next;
                    r_mb  <= w_mb_next;
                    r_cnt <= r_cnt - CW'(1);
                    if (w_last) begin
                        result <= w_x_next;
                        err    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_arithcrypt_seq_core.sv
// Directed bench for arithcrypt_seq_core (WIDTH=8, ROUNDS=4): vector table plus
// hand-written sequences for ignored start, reset abort and ENC/DEC round trips.
module tb_arithcrypt_seq_core;

    localparam int W = 8;
    localparam int R = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         done;
    logic         busy;
    logic         err;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    arithcrypt_seq_core #(.WIDTH(W), .ROUNDS(R)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .result(result), .done(done), .busy(busy), .err(err), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         e;
        int           k;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Issue one request, scramble inputs while busy, and measure latency to done.
    task automatic run_op(input logic [3:0] o, input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output logic [W-1:0] r, output logic e, output int k);
        @(negedge clk);
        start = 1'b1; op = o; a = ia; b = ib;
        @(posedge clk); #1;
        start = 1'b0;
        op = 4'($urandom_range(0, 15));
        a  = W'($urandom_range(0, 255));
        b  = W'($urandom_range(0, 255));
        k  = 1;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        if (!done) check("done_timeout", 32'(done), 32'd1);
        r = result;
        e = err;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] r, enc, dec, got, ra, rb;
        logic         e;
        int           k, dcnt, bcnt, dedge;

        vecs[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 1'b0, 1};
        vecs[1]  = '{4'd1,  8'h05, 8'h07, 8'hFE, 1'b0, 1};
        vecs[2]  = '{4'd2,  8'hAA, 8'hFF, 8'h55, 1'b0, 1};
        vecs[3]  = '{4'd3,  8'h81, 8'h03, 8'h0C, 1'b0, 1};
        vecs[4]  = '{4'd3,  8'h5B, 8'h00, 8'h5B, 1'b0, 1};
        vecs[5]  = '{4'd3,  8'h5B, 8'hFF, 8'hAD, 1'b0, 1};
        vecs[6]  = '{4'd4,  8'h0D, 8'h13, 8'hF7, 1'b0, 9};
        vecs[7]  = '{4'd4,  8'hFF, 8'hFF, 8'h01, 1'b0, 9};
        vecs[8]  = '{4'd4,  8'h00, 8'h00, 8'h00, 1'b0, 9};
        vecs[9]  = '{4'd0,  8'hFF, 8'hFF, 8'hFE, 1'b0, 1};
        vecs[10] = '{4'd5,  8'h3C, 8'h5A, 8'h71, 1'b0, 5};
        vecs[11] = '{4'd6,  8'h71, 8'h5A, 8'h3C, 1'b0, 5};
        vecs[12] = '{4'd9,  8'h12, 8'h34, 8'h00, 1'b1, 1};
        vecs[13] = '{4'd0,  8'h00, 8'h00, 8'h00, 1'b0, 1};
        vecs[14] = '{4'd15, 8'hFF, 8'hFF, 8'h00, 1'b1, 1};
        vecs[15] = '{4'd1,  8'h00, 8'h01, 8'hFF, 1'b0, 1};

        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_result", 32'(result), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, e, k);
            check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
            check($sformatf("vec%0d_err", i), 32'(e), 32'(vecs[i].e));
            check($sformatf("vec%0d_latency", i), 32'(k), 32'(vecs[i].k));
        end

        // err and result hold between operations
        run_op(4'd9, 8'h77, 8'h88, r, e, k);
        repeat (3) @(posedge clk);
        #1;
        check("err_held", 32'(err), 32'd1);
        run_op(4'd0, 8'h01, 8'h02, r, e, k);
        check("err_cleared", 32'(e), 32'd0);
        check("add_after_err", 32'(r), 32'h03);

        // Start pulsed during a MUL is ignored
        @(negedge clk);
        start = 1'b1; op = 4'd4; a = 8'h0D; b = 8'h13;
        @(posedge clk); #1;
        start = 1'b0;
        bcnt = int'(busy); dcnt = 0; dedge = 0; got = '0;
        for (int ed = 2; ed <= 14; ed++) begin
            if (ed == 3) begin
                start = 1'b1; op = 4'd0; a = 8'h01; b = 8'h01;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            bcnt += int'(busy);
            if (done) begin
                dcnt++;
                dedge = ed;
                got = result;
            end
        end
        check("ignored_start_done_count", 32'(dcnt), 32'd1);
        check("ignored_start_done_edge", 32'(dedge), 32'd9);
        check("ignored_start_result", 32'(got), 32'hF7);
        check("mul_busy_edges", 32'(bcnt), 32'd9);

        // Reset in the middle of a MUL aborts it
        @(negedge clk);
        start = 1'b1; op = 4'd4; a = 8'h0D; b = 8'h13;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midreset_result", 32'(result), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        check("midreset_err", 32'(err), 32'd0);
        dcnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            dcnt += int'(done);
        end
        check("midreset_no_done", 32'(dcnt), 32'd0);
        run_op(4'd2, 8'hAA, 8'hFF, r, e, k);
        check("post_reset_xor", 32'(r), 32'h55);
        check("post_reset_latency", 32'(k), 32'd1);

        // DEC undoes ENC for arbitrary data and keys
        for (int t = 0; t < 4; t++) begin
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            run_op(4'd5, ra, rb, enc, e, k);
            run_op(4'd6, enc, rb, dec, e, k);
            check($sformatf("roundtrip%0d", t), 32'(dec), 32'(ra));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
